// File: rtl/branch_cmp_bht_pkg.sv
// Shared CPU branch definitions: predicate-select encoding used by the
// decoder and the ID-stage comparator, plus default datapath widths.
package branch_cmp_bht_pkg;

    localparam int BR_OP_W = 3;

    localparam logic [BR_OP_W-1:0] BR_NONE = 3'd0;
    localparam logic [BR_OP_W-1:0] BR_EQ   = 3'd1;
    localparam logic [BR_OP_W-1:0] BR_NE   = 3'd2;
    localparam logic [BR_OP_W-1:0] BR_LEZ  = 3'd3;
    localparam logic [BR_OP_W-1:0] BR_GTZ  = 3'd4;
    localparam logic [BR_OP_W-1:0] BR_LTZ  = 3'd5;
    localparam logic [BR_OP_W-1:0] BR_GEZ  = 3'd6;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_PC_WIDTH = 32;

    // True for the six real conditional-branch predicates; NONE and the
    // reserved code 7 are not branches.
    function automatic logic br_op_is_branch(input logic [BR_OP_W-1:0] op);
        return (op >= BR_EQ) && (op <= BR_GEZ);
    endfunction

endpackage

// File: rtl/branch_cmp_bht_sat_table.sv
// bht_sat_table: array of saturating taken/not-taken counters with one
// combinational read port (MSB = prediction) and one write port that
// applies a saturating increment/decrement. No read/write bypass: a read
// of the entry being written returns the pre-update value.
module bht_sat_table #(
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2,
    localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    // Weakly not-taken: 0111..1 pattern, e.g. 01 for two-bit counters.
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [CTR_BITS-1:0] r_ctr [BHT_DEPTH];
    logic [CTR_BITS-1:0] w_cur;
    logic [CTR_BITS-1:0] w_next;

    assign o_rd_taken = r_ctr[i_rd_idx][CTR_BITS-1];
    assign w_cur      = r_ctr[i_wr_idx];

    // Saturating step toward the resolved direction.
    always_comb begin
        w_next = w_cur;
        if (i_wr_taken) begin
            if (w_cur != CTR_MAX) w_next = w_cur + CTR_ONE;
        end else begin
            if (w_cur != '0) w_next = w_cur - CTR_ONE;
        end
    end

    // Reset wins over a pending write so an in-flight update is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_ctr[i] <= CTR_INIT;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_next;
        end
    end

endmodule

// File: rtl/branch_cmp_bht.sv
// branch_cmp_bht: ID-stage MIPS branch comparator with a one-cycle resolve
// register and a PC-indexed saturating-counter branch history table.
// Optional statistics counters are built when BRANCH_CMP_STATS_EN is defined.
module branch_cmp_bht
    import branch_cmp_bht_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PC_WIDTH  = DEF_PC_WIDTH,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                if_pred_taken,
    input  logic                id_valid,
    input  logic [BR_OP_W-1:0]  id_br_op,
    input  logic [PC_WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0]    id_rd1,
    input  logic [WIDTH-1:0]    id_rd2,
    input  logic                id_pred_taken,
    output logic                id_taken,
    output logic                res_valid,
    output logic                res_taken,
    output logic                res_mispredict
`ifdef BRANCH_CMP_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_taken,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic             w_pred;
    logic             w_rd1_neg;
    logic             w_rd1_zero;
    logic             w_accept;
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_id_idx;
    logic             w_unused_pc_bits;

    logic             r_res_valid;
    logic             r_res_taken;
    logic             r_res_mispredict;
    logic [IDX_W-1:0] r_upd_idx;

    // Word-aligned PCs: drop the byte offset, keep IDX_W index bits.
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_id_idx = id_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{if_pc, id_pc};

    assign w_rd1_neg  = id_rd1[WIDTH-1];
    assign w_rd1_zero = (id_rd1 == '0);

    // Branch predicate; zero-tests look at rd1 only, as a signed value.
    always_comb begin
        w_pred = 1'b0;
        case (id_br_op)
            BR_EQ:   w_pred = (id_rd1 == id_rd2);
            BR_NE:   w_pred = (id_rd1 != id_rd2);
            BR_LEZ:  w_pred = w_rd1_neg | w_rd1_zero;
            BR_GTZ:  w_pred = ~w_rd1_neg & ~w_rd1_zero;
            BR_LTZ:  w_pred = w_rd1_neg;
            BR_GEZ:  w_pred = ~w_rd1_neg;
            default: w_pred = 1'b0;
        endcase
    end

    assign id_taken = id_valid & w_pred;
    assign w_accept = id_valid & ~stall & br_op_is_branch(id_br_op);

    // Resolve register: single-cycle pulses, loaded once per advancing branch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_res_valid      <= 1'b0;
            r_res_taken      <= 1'b0;
            r_res_mispredict <= 1'b0;
            r_upd_idx        <= '0;
        end else begin
            r_res_valid      <= w_accept;
            r_res_taken      <= w_accept & w_pred;
            r_res_mispredict <= w_accept & (w_pred ^ id_pred_taken);
            if (w_accept) r_upd_idx <= w_id_idx;
        end
    end

    assign res_valid      = r_res_valid;
    assign res_taken      = r_res_taken;
    assign res_mispredict = r_res_mispredict;

    bht_sat_table #(
        .BHT_DEPTH (BHT_DEPTH),
        .CTR_BITS  (CTR_BITS)
    ) u_bht (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_if_idx),
        .o_rd_taken (if_pred_taken),
        .i_wr_en    (r_res_valid),
        .i_wr_idx   (r_upd_idx),
        .i_wr_taken (r_res_taken)
    );

`ifdef BRANCH_CMP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_mispredicts;

    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_branches    <= '0;
            r_stat_taken       <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (r_res_valid)                r_stat_branches    <= r_stat_branches + 32'd1;
            if (r_res_valid & r_res_taken)  r_stat_taken       <= r_stat_taken + 32'd1;
            if (r_res_mispredict)           r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_taken       = r_stat_taken;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: doc/branch_cmp_bht.md
Name: branch_cmp_bht

Overview:
- Parametrised successor to the ID-stage branch comparator.
- Evaluates all MIPS conditional-branch predicates on forwarded register operands: beq, bne, blez, bgtz, bltz, bgez/bgezal-style.
- Registers the resolved outcome one cycle later.
- Maintains a PC-indexed table of saturating counters that supplies a taken/not-taken prediction to IF and flags mispredictions.

Parameters:
- WIDTH, 32, operand width in bits.
- PC_WIDTH, 32, program-counter width.
- BHT_DEPTH, 64, number of counter entries; power of two, 2..1024.
- CTR_BITS, 2, saturating-counter width; 2..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- stall  in  1  ID-stage stall; 1 = the instruction in ID does not advance this cycle.
- if_pc  in  PC_WIDTH  PC being fetched.
- if_pred_taken  out  1  prediction for if_pc; combinational.
- id_valid  in  1  ID holds a real instruction.
- id_br_op  in  3  predicate select (encoding below).
- id_pc  in  PC_WIDTH  PC of the instruction in ID.
- id_rd1  in  WIDTH  first operand (rs), already forwarded.
- id_rd2  in  WIDTH  second operand (rt), already forwarded.
- id_pred_taken  in  1  prediction carried down from IF with this instruction.
- id_taken  out  1  combinational predicate result for ID; 0 when op is NONE.
- res_valid  out  1  registered: a branch resolved last cycle.
- res_taken  out  1  registered outcome.
- res_mispredict  out  1  registered: res_taken != carried prediction.

Behaviour:
- id_br_op encoding:
  - 0 NONE
  - 1 EQ: rd1==rd2
  - 2 NE: rd1!=rd2
  - 3 LEZ: signed rd1<=0
  - 4 GTZ: signed rd1>0
  - 5 LTZ: signed rd1<0
  - 6 GEZ: signed rd1>=0
  - 7 reserved, behaves as NONE.
- Zero-tests use rd1 only, compared as signed WIDTH-bit. Full-width equality.
- id_taken = id_valid & predicate. Pure combinational, no state.
- Index function: idx(pc) = pc[log2(BHT_DEPTH)+1:2]. Word-aligned PCs, so low two bits are ignored.
- if_pred_taken = MSB of counter[idx(if_pc)].
- Resolve register is loaded when accept = id_valid & ~stall & op in 1..6:
  - res_valid <= 1
  - res_taken <= predicate
  - res_mispredict <= predicate ^ id_pred_taken
  - stored update index <= idx(id_pc)
- When not accept, res_valid <= 0. res_taken and res_mispredict <= 0 in that case as well, so they are single-cycle pulses.
- Latency: exactly one cycle from an accepted ID cycle to res_*.
- Stall held for N cycles produces exactly one resolve and one counter update, on the cycle stall drops.
- BHT update happens in the cycle res_valid=1, from the stored index:
  - Taken: counter increments and saturates at 2^CTR_BITS-1.
  - Not taken: counter decrements and saturates at 0.
  - The update writes at the clock edge ending that cycle.
- Same-cycle read/write collision (idx(if_pc) equals the update index while res_valid=1): if_pred_taken reflects the pre-update value. There is no bypass.
- Back-to-back branches at the same index: both updates apply in order.
- Reset (reset=0 at a clock edge):
  - Every counter <= 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2 bits).
  - res_valid, res_taken, res_mispredict <= 0.
  - A pending resolve is discarded and no update occurs.
- In the first cycle after reset, if_pred_taken = 0 for every PC.

Optional Feature:
- Macro: BRANCH_CMP_STATS_EN.
- When defined, add three outputs:
  - stat_branches (32-bit): counts res_valid cycles.
  - stat_taken (32-bit): counts res_valid & res_taken.
  - stat_mispredicts (32-bit): counts res_mispredict.
- All three wrap modulo 2^32 and are cleared by reset.
- When undefined, these ports and counters are absent and the core behaviour is unchanged.

Decomposition:
- Shared cpu package holds:
  - BR_OP width constant and BR_NONE..BR_GEZ localparams, shared with the decoder.
  - Default WIDTH/PC_WIDTH constants.
- Natural sub-module: bht_sat_table. It holds the counter array with one combinational read port, one write port, and the saturate logic; parameters BHT_DEPTH and CTR_BITS.
- The predicate logic and resolve register stay in branch_cmp_bht.

Test Plan:
- Reset then query: hold reset=0 for 2 cycles, release. if_pc=0x3000 → if_pred_taken=0. Any PC → 0. res_valid=0.
- Predicates: EQ with rd1=rd2=0xDEADBEEF → id_taken=1. NE same operands → 0. LTZ with rd1=0x80000000 → 1. GEZ with rd1=0 → 1. GTZ with rd1=0 → 0. LEZ with rd1=0xFFFFFFFF → 1. op=7 → 0.
- Training: issue BEQ at pc=0x3010, taken, id_pred_taken=0, three times:
  - First resolve: res_mispredict=1.
  - After the first update: if_pc=0x3010 → if_pred_taken=1.
  - After the third: counter saturates at 3.
  - One not-taken resolve → still predicts 1.
- Stall: hold stall=1 for 4 cycles with a valid BNE → res_valid stays 0. Drop stall → exactly one res_valid pulse one cycle later and one counter change.
- Collision plus reset: update index 0x3010 while if_pc=0x3010 → prediction shows the old value that cycle and the new value the next. Assert reset in the cycle the resolve register is valid → no counter change, and all outputs are 0 the following cycle.
- With BRANCH_CMP_STATS_EN: 5 branches, of which 3 taken and 2 mispredicted → stat_branches=5, stat_taken=3, stat_mispredicts=2. Reset → all 0.
